// File: rtl/scpad_pkg.sv
// Scratchpad shared types plus the DRAM write-beat types used by the drain/latch paths.
package scpad_pkg;
  localparam int SCPAD_DATA_W  = 512;
  localparam int SCPAD_ELEM_W  = 16;
  localparam int MASK_W        = SCPAD_DATA_W / SCPAD_ELEM_W;
  localparam int DRAM_BEAT_W   = 64;
  localparam int BEATS_PER_ROW = 8;

  typedef logic [SCPAD_DATA_W-1:0] scpad_data_t;
  typedef logic [MASK_W-1:0]       mask_t;
  typedef logic [DRAM_BEAT_W-1:0]  dram_beat_t;
  typedef logic [7:0]              dram_strb_t;
  typedef logic [2:0]              beat_idx_t;

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} drain_state_t;

  // Each 16-bit element covers two bytes, so one mask bit drives a strobe pair.
  function automatic dram_strb_t mask_to_strb(mask_t m, beat_idx_t idx);
    dram_strb_t s;
    s = '0;
    for (int k = 0; k < 4; k++)
      s[2*k +: 2] = {2{m[4*int'(idx) + k]}};
    return s;
  endfunction
endpackage

// File: rtl/sram_read_drain.sv
// Serializes one 512-bit scratchpad row into 1-8 ordered 64-bit DRAM write beats.
// Optional SCPAD_DRAIN_PIPE_EN: accept the next row on the last-beat handshake (no bubble).
module sram_read_drain
  import scpad_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        sram_rd_valid,
  output logic        sram_rd_ready,
  input  scpad_data_t sram_rd_data,
  input  mask_t       sram_rd_mask,
  input  logic [7:0]  dram_id,
  input  logic [2:0]  num_request,
  output logic        dram_wr_valid,
  input  logic        dram_wr_ready,
  output dram_beat_t  dram_wr_data,
  output dram_strb_t  dram_wr_strb,
  output logic [7:0]  dram_wr_id,
  output logic        dram_wr_last,
  output logic        busy
);
  drain_state_t state;
  beat_idx_t    beat_idx, nreq_q;
  scpad_data_t  row_q;
  mask_t        mask_q;
  logic         load;
  beat_idx_t    beat_nxt;

`ifdef SCPAD_DRAIN_PIPE_EN
  assign sram_rd_ready = (state == IDLE) | ((state == SEND) & dram_wr_last & dram_wr_ready);
`else
  assign sram_rd_ready = (state == IDLE);
`endif

  assign load     = sram_rd_valid & sram_rd_ready;
  assign beat_nxt = beat_idx + 3'd1;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state         <= IDLE;
      beat_idx      <= '0;
      nreq_q        <= '0;
      row_q         <= '0;
      mask_q        <= '0;
      dram_wr_valid <= 1'b0;
      dram_wr_data  <= '0;
      dram_wr_strb  <= '0;
      dram_wr_id    <= '0;
      dram_wr_last  <= 1'b0;
      busy          <= 1'b0;
    end else if (load) begin
      // Beat 0 is presented straight from the incoming row so it is valid next cycle.
      state         <= SEND;
      beat_idx      <= '0;
      nreq_q        <= num_request;
      row_q         <= sram_rd_data;
      mask_q        <= sram_rd_mask;
      dram_wr_valid <= 1'b1;
      dram_wr_data  <= sram_rd_data[DRAM_BEAT_W-1:0];
      dram_wr_strb  <= mask_to_strb(sram_rd_mask, 3'd0);
      dram_wr_id    <= dram_id;
      dram_wr_last  <= (num_request == 3'd0);
      busy          <= 1'b1;
    end else if (state == SEND && dram_wr_ready) begin
      if (dram_wr_last) begin
        state         <= IDLE;
        dram_wr_valid <= 1'b0;
        dram_wr_last  <= 1'b0;
        busy          <= 1'b0;
      end else begin
        beat_idx     <= beat_nxt;
        dram_wr_data <= row_q[int'(beat_nxt)*DRAM_BEAT_W +: DRAM_BEAT_W];
        dram_wr_strb <= mask_to_strb(mask_q, beat_nxt);
        dram_wr_last <= (beat_nxt == nreq_q);
      end
    end
  end
endmodule
